fsm_step_controller: RTL and testbench

Sequencing controller for the on-board FSM demos (sequence detectors with 7-segment state display). It replaces the ad-hoc divided clock with a single-cycle `step_en` pulse in the `clk` domain and supplies the detector's serial input bit `x_out`. It selects the step source: free-running divider, debounced push-button single-step, or playback of a loaded bit pattern. It sits between board I/O (switch, button) and any FSM datapath clocked by `clk` and gated by `step_en`.

---
 rtl/fsm_step_pkg.sv | 29 ++
 rtl/fsm_step_controller_if.sv | 37 +++
 rtl/btn_debounce.sv | 53 +++++
 rtl/fsm_step_controller.sv | 165 ++++++++++++++++
 tb/tb_fsm_step_controller.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/fsm_step_pkg.sv
// Shared types for the FSM demo step controller: mode codes, play states, counter widths.
// Latency: none (declarations only).
// Backpressure: none.
package fsm_step_pkg;

  typedef enum logic [1:0] {
    MODE_HOLD   = 2'b00,
    MODE_FREE   = 2'b01,
    MODE_SINGLE = 2'b10,
    MODE_PLAY   = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } play_state_e;

  localparam int STEP_CNT_W = 8;
  localparam int PAT_LEN_W  = 5;

  // Lengths beyond the pattern register width play the whole register.
  function automatic logic [PAT_LEN_W-1:0] clamp_len(input logic [PAT_LEN_W-1:0] len,
                                                     input int max_len);
    if (int'(len) > max_len) return PAT_LEN_W'(max_len);
    return len;
  endfunction

endpackage

// File: rtl/fsm_step_controller_if.sv
// Board-side control bundle of the step controller: mode, divider, pattern and step outputs.
// Latency: none (wiring only).
// Backpressure: none; every strobe is a single-cycle pulse with no handshake.
interface fsm_step_controller_if #(
  parameter int DIV_WIDTH   = 27,
  parameter int PAT_LEN_MAX = 16
);
  import fsm_step_pkg::*;

  mode_e                  mode;
  logic                   div_load;
  logic [DIV_WIDTH-1:0]   div_value;
  logic                   btn;
  logic                   x_in;
  logic                   pat_load;
  logic [PAT_LEN_MAX-1:0] pat_data;
  logic [PAT_LEN_W-1:0]   pat_len;
  logic                   start;
  logic                   step_en;
  logic                   x_out;
  logic                   busy;
  logic                   done;
  logic [STEP_CNT_W-1:0]  step_count;

  // Board / host side: drives the controls, watches the step outputs.
  modport master (
    output mode, div_load, div_value, btn, x_in, pat_load, pat_data, pat_len, start,
    input  step_en, x_out, busy, done, step_count
  );

  // Controller side.
  modport slave (
    input  mode, div_load, div_value, btn, x_in, pat_load, pat_data, pat_len, start,
    output step_en, x_out, busy, done, step_count
  );

endinterface

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-FF synchronizer, stability filter, one-cycle pulse on accepted rise.
// Latency: press is high 2 + DEB_CYCLES cycles after a clean raw rise.
// Backpressure: none; press is a free-running pulse, release produces nothing.
module btn_debounce #(
  parameter int DEB_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic press
);

  localparam int            CW       = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic          sync_1;
  logic          sync_2;
  logic          level;
  logic [CW-1:0] stable_cnt;

  // Bring the raw button into the clk domain.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_1 <= 1'b0;
      sync_2 <= 1'b0;
    end else begin
      sync_1 <= btn;
      sync_2 <= sync_1;
    end
  end

  // Accept a new level only after it has differed from the current one for DEB_CYCLES cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      level      <= 1'b0;
      stable_cnt <= '0;
      press      <= 1'b0;
    end else begin
      press <= 1'b0;
      if (sync_2 == level) begin
        stable_cnt <= '0;
      end else if (stable_cnt == CNT_LAST) begin
        level      <= sync_2;
        stable_cnt <= '0;
        press      <= sync_2;
      end else begin
        stable_cnt <= stable_cnt + CNT_ONE;
      end
    end
  end

endmodule

// File: rtl/fsm_step_controller.sv
// Step sequencer for FSM demos: divider, button single-step or pattern playback -> step_en/x_out.
// Latency: FREE step every P cycles; SINGLE step 2+DEB_CYCLES+1 after press; PLAY step on each tick.
// Backpressure: none; all outputs are registered pulses/levels, step_en never two cycles in a row.
module fsm_step_controller #(
  parameter int DIV_WIDTH   = 27,
  parameter int DIV_DEFAULT = 20000000,
  parameter int DEB_CYCLES  = 1000000,
  parameter int PAT_LEN_MAX = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  fsm_step_controller_if.slave bus
);
  import fsm_step_pkg::*;

  localparam int                    PTR_W      = (PAT_LEN_MAX > 1) ? $clog2(PAT_LEN_MAX) : 1;
  localparam logic [DIV_WIDTH-1:0]  DIV_ONE    = DIV_WIDTH'(1);
  localparam logic [DIV_WIDTH-1:0]  PERIOD_MIN = DIV_WIDTH'(2);
  localparam logic [DIV_WIDTH-1:0]  PERIOD_RST = (DIV_DEFAULT < 2) ? PERIOD_MIN
                                                                   : DIV_WIDTH'(DIV_DEFAULT);
  localparam logic [PTR_W-1:0]      PTR_ONE    = PTR_W'(1);
  localparam logic [PAT_LEN_W-1:0]  LEN_ONE    = PAT_LEN_W'(1);
  localparam logic [STEP_CNT_W-1:0] STEP_ONE   = STEP_CNT_W'(1);

  // Divider
  logic [DIV_WIDTH-1:0] div_cnt;
  logic [DIV_WIDTH-1:0] div_period;
  logic                 tick;

  assign tick = (div_cnt == div_period - DIV_ONE);

  // Free-running 0..P-1 counter; a load restarts it from zero with the clamped period.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt    <= '0;
      div_period <= PERIOD_RST;
    end else if (bus.div_load) begin
      div_cnt    <= '0;
      div_period <= (bus.div_value < PERIOD_MIN) ? PERIOD_MIN : bus.div_value;
    end else if (tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + DIV_ONE;
    end
  end

  // Switch input: synchronizer only, it is sampled on step edges so bounce is harmless.
  logic x_sync_1;
  logic x_sync_2;

  // Bring the raw switch bit into the clk domain.
  always_ff @(posedge clk) begin
    if (rst) begin
      x_sync_1 <= 1'b0;
      x_sync_2 <= 1'b0;
    end else begin
      x_sync_1 <= bus.x_in;
      x_sync_2 <= x_sync_1;
    end
  end

  logic press;

  btn_debounce #(
    .DEB_CYCLES (DEB_CYCLES)
  ) u_btn_debounce (
    .clk   (clk),
    .rst   (rst),
    .btn   (bus.btn),
    .press (press)
  );

  // Step request for the switch-driven modes; PLAY is handled by the FSM itself.
  logic src_step;

  // Select the step source for FREE/SINGLE.
  always_comb begin
    src_step = 1'b0;
    case (bus.mode)
      MODE_FREE:   src_step = tick;
      MODE_SINGLE: src_step = press;
      default:     src_step = 1'b0;
    endcase
  end

  // Play FSM and registered outputs
  play_state_e             state;
  logic [PAT_LEN_MAX-1:0]  pat_q;
  logic [PAT_LEN_W-1:0]    len_q;
  logic [PTR_W-1:0]        ptr;
  logic                    step_q;
  logic                    x_q;
  logic                    busy_q;
  logic                    done_q;
  logic [STEP_CNT_W-1:0]   step_cnt_q;
  logic                    play_start;

  // A same-cycle load takes precedence, so start is only honoured without pat_load.
  assign play_start = bus.start && (bus.mode == MODE_PLAY) && (len_q != '0) && !bus.pat_load;

  // Playback sequencing plus the shared step/x/count outputs; the !step_q guard keeps
  // step_en from ever lasting two cycles even across a mode change.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      pat_q      <= '0;
      len_q      <= '0;
      ptr        <= '0;
      step_q     <= 1'b0;
      x_q        <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      step_cnt_q <= '0;
    end else begin
      step_q <= 1'b0;
      done_q <= 1'b0;

      if (src_step && !step_q) begin
        step_q     <= 1'b1;
        x_q        <= x_sync_2;
        step_cnt_q <= step_cnt_q + STEP_ONE;
      end

      case (state)
        IDLE: begin
          if (bus.pat_load) begin
            pat_q <= bus.pat_data;
            len_q <= clamp_len(bus.pat_len, PAT_LEN_MAX);
          end else if (play_start) begin
            state  <= RUN;
            ptr    <= PTR_W'(len_q - LEN_ONE);
            busy_q <= 1'b1;
          end
        end
        RUN: begin
          if (bus.mode != MODE_PLAY) begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end else if (tick && !step_q) begin
            step_q     <= 1'b1;
            x_q        <= pat_q[ptr];
            step_cnt_q <= step_cnt_q + STEP_ONE;
            ptr        <= ptr - PTR_ONE;
            if (ptr == '0) begin
              state  <= DONE;
              busy_q <= 1'b0;
            end
          end
        end
        DONE: begin
          done_q <= 1'b1;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.step_en    = step_q;
  assign bus.x_out      = x_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.step_count = step_cnt_q;

endmodule

// File: tb/tb_fsm_step_controller.sv
// Directed bench for fsm_step_controller with DEB_CYCLES=8 and DIV_DEFAULT=4.
// Latency: inputs driven and outputs sampled on the falling clock edge.
// Backpressure: n/a; every wait is bounded by a fixed cycle window.
module tb_fsm_step_controller;
  import fsm_step_pkg::*;

  localparam int DIV_WIDTH   = 27;
  localparam int PAT_LEN_MAX = 16;

  logic clk = 1'b0;
  logic rst;
  int   n_chk  = 0;
  int   n_pass = 0;

  fsm_step_controller_if #(.DIV_WIDTH(DIV_WIDTH), .PAT_LEN_MAX(PAT_LEN_MAX)) bus ();

  fsm_step_controller #(
    .DIV_WIDTH   (DIV_WIDTH),
    .DIV_DEFAULT (4),
    .DEB_CYCLES  (8),
    .PAT_LEN_MAX (PAT_LEN_MAX)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic observe(input int n, output int steps, output logic [31:0] seq,
                         output int dones, output int busys);
    steps = 0; seq = '0; dones = 0; busys = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (bus.step_en) begin
        steps++;
        seq = {seq[30:0], bus.x_out};
      end
      if (bus.done) dones++;
      if (bus.busy) busys++;
    end
  endtask

  task automatic load_pat(input logic [15:0] d, input logic [4:0] l, input logic with_start);
    bus.pat_data = d;
    bus.pat_len  = l;
    bus.pat_load = 1'b1;
    bus.start    = with_start;
    @(negedge clk);
    bus.pat_load = 1'b0;
    bus.start    = 1'b0;
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got no completion, expected finish before 1 ms");
    $fatal(1);
  end

  initial begin
    int          steps, dones, busys, first_k;
    logic [31:0] seq, v_step, v_busy, v_done;
    logic        x_first;

    rst           = 1'b1;
    bus.mode      = MODE_FREE;
    bus.div_load  = 1'b0;
    bus.div_value = '0;
    bus.btn       = 1'b0;
    bus.x_in      = 1'b1;
    bus.pat_load  = 1'b0;
    bus.pat_data  = '0;
    bus.pat_len   = '0;
    bus.start     = 1'b0;
    cyc(3);
    check("rst_step_en", 32'(bus.step_en), 32'd0);
    check("rst_x_out",   32'(bus.x_out),   32'd0);
    check("rst_busy",    32'(bus.busy),    32'd0);
    check("rst_done",    32'(bus.done),    32'd0);
    check("rst_count",   32'(bus.step_count), 32'd0);

    // FREE, P=4: steps on cycles 4, 8, 12 after reset release
    rst = 1'b0;
    v_step = '0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      v_step[c] = bus.step_en;
    end
    check("free_step_pattern", v_step, 32'h0000_1110);
    check("free_x_out", 32'(bus.x_out), 32'd1);
    check("free_count", 32'(bus.step_count), 32'd3);

    // div_load of 0 clamps to 2: first step 2 cycles after the load, then every 2
    bus.div_value = '0;
    bus.div_load  = 1'b1;
    @(negedge clk);
    bus.div_load = 1'b0;
    v_step = '0;
    for (int j = 1; j <= 5; j++) begin
      @(negedge clk);
      v_step[j] = bus.step_en;
    end
    check("div2_step_pattern", v_step, 32'h0000_0014);
    check("div2_count", 32'(bus.step_count), 32'd5);

    // SINGLE: 3-cycle glitch is filtered
    bus.mode = MODE_SINGLE;
    bus.x_in = 1'b0;
    bus.btn  = 1'b1;
    cyc(3);
    bus.btn = 1'b0;
    observe(25, steps, seq, dones, busys);
    check("glitch_no_step", 32'(steps), 32'd0);

    // SINGLE: clean press, one step 11 cycles after the rise
    bus.btn = 1'b1;
    first_k = 0;
    steps   = 0;
    x_first = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (bus.step_en) begin
        steps++;
        if (first_k == 0) begin
          first_k = k;
          x_first = bus.x_out;
        end
      end
    end
    check("press_latency", 32'(first_k), 32'd11);
    check("press_one_step", 32'(steps), 32'd1);
    check("press_x_out", 32'(x_first), 32'd0);
    bus.btn = 1'b0;
    observe(25, steps, seq, dones, busys);
    check("release_no_step", 32'(steps), 32'd0);
    check("single_count", 32'(bus.step_count), 32'd6);

    // PLAY 0x0009 len 4 with P=4, cycle-exact step/busy/done maps
    bus.mode      = MODE_HOLD;
    bus.div_value = DIV_WIDTH'(4);
    bus.div_load  = 1'b1;
    bus.pat_data  = 16'h0009;
    bus.pat_len   = 5'd4;
    bus.pat_load  = 1'b1;
    @(negedge clk);
    bus.div_load = 1'b0;
    bus.pat_load = 1'b0;
    bus.mode     = MODE_PLAY;
    bus.start    = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    v_step = '0; v_busy = '0; v_done = '0; seq = '0;
    for (int k = 0; k <= 24; k++) begin
      if (k > 0) @(negedge clk);
      v_step[k] = bus.step_en;
      v_busy[k] = bus.busy;
      v_done[k] = bus.done;
      if (bus.step_en) seq = {seq[30:0], bus.x_out};
    end
    check("play_step_map", v_step, 32'h0000_8888);
    check("play_busy_map", v_busy, 32'h0000_7FFF);
    check("play_done_map", v_done, 32'h0001_0000);
    check("play_x_seq", seq, 32'h0000_0009);
    check("play_count", 32'(bus.step_count), 32'd10);

    // Zero-length pattern: start ignored
    load_pat(16'hFFFF, 5'd0, 1'b0);
    pulse_start();
    observe(16, steps, seq, dones, busys);
    check("len0_no_step", 32'(steps), 32'd0);
    check("len0_no_busy", 32'(busys), 32'd0);

    // Load and start together: load only, then a plain start plays the new pattern
    load_pat(16'h0000, 5'd2, 1'b0);
    load_pat(16'h0005, 5'd3, 1'b1);
    observe(12, steps, seq, dones, busys);
    check("loadwin_no_busy", 32'(busys), 32'd0);
    check("loadwin_no_step", 32'(steps), 32'd0);
    pulse_start();
    observe(30, steps, seq, dones, busys);
    check("loadwin_steps", 32'(steps), 32'd3);
    check("loadwin_x_seq", seq, 32'h0000_0005);
    check("loadwin_done", 32'(dones), 32'd1);
    check("loadwin_count", 32'(bus.step_count), 32'd13);

    // Length 20 clamps to 16
    load_pat(16'h8001, 5'd20, 1'b0);
    pulse_start();
    observe(80, steps, seq, dones, busys);
    check("clamp_steps", 32'(steps), 32'd16);
    check("clamp_x_seq", seq, 32'h0000_8001);
    check("clamp_done", 32'(dones), 32'd1);
    check("clamp_count", 32'(bus.step_count), 32'd29);

    // Abort: mode change mid-RUN
    load_pat(16'h00FF, 5'd8, 1'b0);
    pulse_start();
    steps = 0;
    for (int i = 0; i < 40 && steps < 2; i++) begin
      @(negedge clk);
      if (bus.step_en) steps++;
    end
    check("abort_two_steps", 32'(steps), 32'd2);
    bus.mode = MODE_HOLD;
    @(negedge clk);
    check("abort_busy_drop", 32'(bus.busy), 32'd0);
    observe(40, steps, seq, dones, busys);
    check("abort_no_step", 32'(steps), 32'd0);
    check("abort_no_done", 32'(dones), 32'd0);

    // Reset mid-RUN
    bus.mode = MODE_PLAY;
    pulse_start();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.step_en) break;
    end
    check("midrun_step_seen", 32'(bus.step_en), 32'd1);
    check("midrun_busy", 32'(bus.busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("rstrun_step_en", 32'(bus.step_en), 32'd0);
    check("rstrun_x_out",   32'(bus.x_out),   32'd0);
    check("rstrun_busy",    32'(bus.busy),    32'd0);
    check("rstrun_done",    32'(bus.done),    32'd0);
    check("rstrun_count",   32'(bus.step_count), 32'd0);
    rst = 1'b0;
    pulse_start();
    observe(16, steps, seq, dones, busys);
    check("rstrun_len_cleared", 32'(busys), 32'd0);
    check("rstrun_no_step", 32'(steps), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
